// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display blocks.
// Holds the hex glyph table, the scan state encoding and the anode select helper.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GUARD,
    ST_SHOW
  } seg_state_e;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0-F.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] an_sel(input logic [3:0] idx);
    return ~(16'h0001 << idx);
  endfunction

endpackage

// File: rtl/seg_hex7_dec.sv
// Nibble + decimal point + blank -> active-low {dp,g,f,e,d,c,b,a}.
// Blank darkens the glyph only; the point follows point_i.
module seg_hex7_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       point_i,
  input  logic       blank_i,
  output logic [7:0] code_o
);

  logic [6:0] glyph;

  always_comb begin
    glyph = hex7(nib_i);
    if (blank_i) glyph = 7'h7F;
  end

  assign code_o = {~point_i, glyph};

endmodule

// File: rtl/seg_scan_mux.sv
// Self-scanning multiplexed 7-segment controller with guard blanking and blink.
// Optional leading-zero blanking in text mode when SEG_LZB_EN is defined.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        text,
  input  logic [4*DIGITS-1:0]         hex_data,
  input  logic [8*DIGITS-1:0]         raw_seg,
  input  logic [DIGITS-1:0]           points,
  input  logic [DIGITS-1:0]           blink,
  output logic [7:0]                  segment,
  output logic [DIGITS-1:0]           an,
  output logic [$clog2(DIGITS)-1:0]   digit_idx,
  output logic                        frame_done
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  seg_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          ph_q, ph_d;
  logic          fd_q, fd_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          cap;

  logic [4*DIGITS-1:0] hex_q, hex_d;
  logic [8*DIGITS-1:0] raw_q, raw_d;
  logic [DIGITS-1:0]   pts_q, pts_d;
  logic [DIGITS-1:0]   blk_q, blk_d;
  logic                txt_q, txt_d;

  logic [3:0] nib;
  logic [7:0] raw_byte;
  logic [7:0] hex_code;
  logic       blank;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frm_d   = frm_q;
    ph_d    = ph_q;
    fd_d    = 1'b0;
    cap     = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cap     = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_GUARD;
        end
        ST_GUARD: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(GUARD - 1)) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_d   = '0;
            state_d = ST_GUARD;
            if (idx_q == IW'(DIGITS - 1)) begin
              idx_d = '0;
              fd_d  = 1'b1;
              cap   = 1'b1;
              if (frm_q == FW'(BLINK_FRAMES - 1)) begin
                frm_d = '0;
                ph_d  = ~ph_q;
              end else begin
                frm_d = frm_q + 1'b1;
              end
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Shadow next-state feeds the decoder so a fresh capture is shown at once.
  assign hex_d = cap ? hex_data : hex_q;
  assign raw_d = cap ? raw_seg  : raw_q;
  assign pts_d = cap ? points   : pts_q;
  assign blk_d = cap ? blink    : blk_q;
  assign txt_d = cap ? text     : txt_q;

  assign nib      = hex_d[{idx_d, 2'b00} +: 4];
  assign raw_byte = raw_d[{idx_d, 3'b000} +: 8];

`ifdef SEG_LZB_EN
  logic [DIGITS-1:0] lzb_q, lzb_d, lzb_n;
  logic              lz_run;

  always_comb begin
    lz_run = 1'b1;
    lzb_n  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run   = lz_run & (hex_data[4*i +: 4] == 4'h0);
      lzb_n[i] = lz_run;
    end
  end

  assign lzb_d = cap ? lzb_n : lzb_q;
  assign blank = (blk_d[idx_d] & ph_d) | lzb_d[idx_d];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lzb_q <= '0;
    else        lzb_q <= lzb_d;
  end
`else
  assign blank = blk_d[idx_d] & ph_d;
`endif

  seg_hex7_dec u_dec (
    .nib_i   (nib),
    .point_i (pts_d[idx_d]),
    .blank_i (blank),
    .code_o  (hex_code)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    if (state_d != ST_IDLE) seg_d = txt_d ? hex_code : raw_byte;
    if (state_d == ST_SHOW) an_d = DIGITS'(an_sel(4'(idx_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      ph_q    <= 1'b0;
      fd_q    <= 1'b0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      hex_q   <= '0;
      raw_q   <= '0;
      pts_q   <= '0;
      blk_q   <= '0;
      txt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      ph_q    <= ph_d;
      fd_q    <= fd_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      hex_q   <= hex_d;
      raw_q   <= raw_d;
      pts_q   <= pts_d;
      blk_q   <= blk_d;
      txt_q   <= txt_d;
    end
  end

  assign segment    = seg_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: 4 digits, 8-cycle slots, 2-cycle guard.
// Frame vectors come from a table; enable, reset and blink cases are hand-written.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        text;
  logic [15:0] hex_data;
  logic [31:0] raw_seg;
  logic [3:0]  points;
  logic [3:0]  blink;
  logic [7:0]  segment;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .DIGITS(4), .SCAN_DIV(8), .GUARD(2), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .text(text),
    .hex_data(hex_data), .raw_seg(raw_seg),
    .points(points), .blink(blink),
    .segment(segment), .an(an),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  typedef struct {
    logic        text;
    logic [15:0] hex;
    logic [31:0] raw;
    logic [3:0]  pts;
    logic [3:0]  blk;
    logic [31:0] segs;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic dark(input string tag);
    @(negedge clk);
    chk({tag, " an"}, 32'(an), 32'hF);
    chk({tag, " seg"}, 32'(segment), 32'hFF);
    chk({tag, " idx"}, 32'(digit_idx), 32'h0);
    chk({tag, " fd"}, 32'(frame_done), 32'h0);
  endtask

  task automatic cyc(input string tag, input int c,
                     input logic [31:0] segs, input bit fd);
    int s;
    int p;
    logic [3:0] ea;
    logic [7:0] es;
    s  = c / 8;
    p  = c % 8;
    ea = (p < 2) ? 4'hF : ~(4'b0001 << s);
    es = segs[s*8 +: 8];
    @(negedge clk);
    chk($sformatf("%s c%0d an", tag, c), 32'(an), 32'(ea));
    chk($sformatf("%s c%0d seg", tag, c), 32'(segment), 32'(es));
    chk($sformatf("%s c%0d idx", tag, c), 32'(digit_idx), s);
    chk($sformatf("%s c%0d fd", tag, c), 32'(frame_done),
        32'((c == 0) && fd));
  endtask

  task automatic frame(input string tag, input logic [31:0] segs,
                       input bit fd);
    for (int c = 0; c < 32; c++) cyc(tag, c, segs, fd);
  endtask

  task automatic start(input logic t, input logic [15:0] h,
                       input logic [31:0] r, input logic [3:0] p,
                       input logic [3:0] b);
    en = 1'b0;
    rst_n = 1'b0;
    text = t;
    hex_data = h;
    raw_seg = r;
    points = p;
    blink = b;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
  endtask

  logic [31:0] zsegs;
  logic [7:0]  d0;

  initial begin
    vecs[0] = '{1'b1, 16'h1A2F, 32'h0, 4'h0, 4'h0, 32'hF988A48E};
`ifdef SEG_LZB_EN
    vecs[1] = '{1'b1, 16'h0000, 32'h0, 4'h0, 4'h0, 32'hFFFFFFC0};
`else
    vecs[1] = '{1'b1, 16'h0000, 32'h0, 4'h0, 4'h0, 32'hC0C0C0C0};
`endif
    vecs[2] = '{1'b0, 16'h0000, 32'h12345678, 4'hF, 4'hF, 32'h12345678};
    vecs[3] = '{1'b1, 16'h89B3, 32'h0, 4'hA, 4'h0, 32'h009003B0};
`ifdef SEG_LZB_EN
    vecs[4] = '{1'b1, 16'h0070, 32'h0, 4'h0, 4'h0, 32'hFFFFF8C0};
`else
    vecs[4] = '{1'b1, 16'h0070, 32'h0, 4'h0, 4'h0, 32'hC0C0F8C0};
`endif
    zsegs = vecs[1].segs;

    rst_n = 1'b0;
    en = 1'b0;
    text = 1'b1;
    hex_data = 16'h1A2F;
    raw_seg = 32'h0;
    points = 4'h0;
    blink = 4'h0;
    dark("reset");
    @(negedge clk);
    rst_n = 1'b1;
    dark("idle");
    dark("idle2");

    for (int v = 0; v < 5; v++) begin
      start(vecs[v].text, vecs[v].hex, vecs[v].raw,
            vecs[v].pts, vecs[v].blk);
      for (int f = 0; f < 3; f++)
        frame($sformatf("vec%0d f%0d", v, f), vecs[v].segs, f > 0);
    end

    start(1'b1, 16'h1A2F, 32'h0, 4'h0, 4'h0);
    for (int c = 0; c < 32; c++) begin
      if (c == 10) hex_data = 16'h0000;
      cyc("midupd", c, 32'hF988A48E, 1'b0);
    end
    frame("midupd next", zsegs, 1'b1);

    start(1'b1, 16'h123F, 32'h0, 4'h1, 4'h1);
    for (int f = 0; f < 5; f++) begin
      d0 = ((f / 2) % 2 == 1) ? 8'h7F : 8'h0E;
      frame($sformatf("blink f%0d", f), {24'hF9A4B0, d0}, f > 0);
    end

    start(1'b1, 16'h1A2F, 32'h0, 4'h0, 4'h0);
    for (int c = 0; c < 20; c++) cyc("endrop", c, 32'hF988A48E, 1'b0);
    en = 1'b0;
    dark("endrop off0");
    dark("endrop off1");
    dark("endrop off2");
    en = 1'b1;
    for (int c = 0; c < 31; c++) cyc("reen", c, 32'hF988A48E, 1'b0);
    en = 1'b0;
    dark("endrop last");
    en = 1'b1;
    for (int c = 0; c < 12; c++) cyc("arst pre", c, 32'hF988A48E, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst an", 32'(an), 32'hF);
    chk("arst seg", 32'(segment), 32'hFF);
    chk("arst idx", 32'(digit_idx), 32'h0);
    chk("arst fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    frame("arst post", 32'hF988A48E, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
